// File: rtl/tc_delay_queue.sv
// tc_delay_queue: DEPTH-entry FIFO with registered 1-tick read latency and sticky overflow/underflow flags.
// Define TC_DELAY_QUEUE_BYPASS_EN to forward `in` straight to `out` on push+pop while empty.
module tc_delay_queue #(
    parameter int UUID      = 0,
    parameter     NAME      = "",
    parameter int BIT_WIDTH = 8,
    parameter int DEPTH     = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [BIT_WIDTH-1:0]       in,
    input  logic                       pop,
    output logic [BIT_WIDTH-1:0]       out,
    output logic                       out_valid,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty,
    output logic                       overflow,
    output logic                       underflow
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    logic [BIT_WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0] wp, rp;
    logic pop_acc, push_acc, bypass;
    logic [31:0] unused_id;
    assign unused_id = UUID ^ 32'($bits(NAME));
    assign full  = count == CW'(DEPTH);
    assign empty = count == '0;
`ifdef TC_DELAY_QUEUE_BYPASS_EN
    assign bypass = empty && push && pop;
`else
    assign bypass = 1'b0;
`endif
    assign pop_acc  = pop && !empty;
    // A pop in the same tick frees the slot, so a full queue still accepts the write.
    assign push_acc = push && (!full || pop_acc) && !bypass;
    always_ff @(posedge clk) begin
        if (push_acc) mem[wp] <= in;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            wp        <= '0;
            rp        <= '0;
            count     <= '0;
            out       <= '0;
            out_valid <= 1'b0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            wp        <= push_acc ? wp + 1'b1 : wp;
            rp        <= pop_acc ? rp + 1'b1 : rp;
            count     <= (push_acc && !pop_acc) ? count + 1'b1 :
                         (pop_acc && !push_acc) ? count - 1'b1 : count;
            out       <= pop_acc ? mem[rp] : bypass ? in : out;
            out_valid <= pop_acc || bypass;
            overflow  <= overflow || (push && full && !pop_acc);
            underflow <= underflow || (pop && empty && !bypass);
        end
    end
endmodule

// File: tb/tb_tc_delay_queue.sv
// tb_tc_delay_queue: directed stimulus with a scoreboard of expected popped words checked by a decoupled monitor.
module tb_tc_delay_queue;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       push = 1'b0;
    logic [7:0] in = 8'h00;
    logic       pop = 1'b0;
    logic [7:0] out;
    logic       out_valid;
    logic [2:0] count;
    logic       full, empty, overflow, underflow;
    int vectors = 0;
    int errors = 0;
    logic [7:0] mq[$];
    logic [7:0] exp_q[$];

    tc_delay_queue #(.UUID(1), .NAME("q0"), .BIT_WIDTH(8), .DEPTH(4)) dut (
        .clk(clk), .rst(rst), .push(push), .in(in), .pop(pop),
        .out(out), .out_valid(out_valid), .count(count), .full(full),
        .empty(empty), .overflow(overflow), .underflow(underflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Inputs are applied, the reference occupancy model is advanced and expected words queued, then one edge elapses.
    task automatic step(input bit pu, input logic [7:0] d, input bit po);
        bit emp, ful, pa, byp;
        push = pu; in = d; pop = po;
        emp = mq.size() == 0;
        ful = mq.size() == 4;
        pa  = po && !emp;
`ifdef TC_DELAY_QUEUE_BYPASS_EN
        byp = emp && pu && po;
`else
        byp = 1'b0;
`endif
        if (byp) exp_q.push_back(d);
        if (pa) exp_q.push_back(mq.pop_front());
        if (pu && (!ful || pa) && !byp) mq.push_back(d);
        @(posedge clk);
        #1;
        push = 1'b0; pop = 1'b0;
    endtask

    initial begin
        fork
            forever begin
                @(negedge clk);
                if (out_valid) begin
                    if (exp_q.size() == 0) chk("spurious_valid", 32'(out_valid), 32'd0);
                    else chk("out", 32'(out), 32'(exp_q.pop_front()));
                end
            end
        join_none
        push = 1'b1; in = 8'hAA;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_count", 32'(count), 0);
        chk("rst_empty", 32'(empty), 1);
        chk("rst_full", 32'(full), 0);
        chk("rst_out", 32'(out), 0);
        chk("rst_valid", 32'(out_valid), 0);
        chk("rst_flags", 32'({overflow, underflow}), 0);
        rst = 1'b0; push = 1'b0;

        step(1, 8'h11, 0); step(1, 8'h22, 0); step(1, 8'h33, 0);
        chk("ord_count3", 32'(count), 3);
        repeat (3) step(0, 8'h00, 1);
        chk("ord_last", 32'(out), 32'h33);
        chk("ord_count0", 32'(count), 0);
        step(0, 8'h00, 0);
        chk("hold_valid", 32'(out_valid), 0);
        chk("hold_out", 32'(out), 32'h33);

        for (int i = 1; i <= 4; i++) step(1, 8'(i), 0);
        chk("full", 32'(full), 1);
        step(1, 8'h05, 0);
        chk("overflow", 32'(overflow), 1);
        chk("ovf_count", 32'(count), 4);
        repeat (4) step(0, 8'h00, 1);
        chk("drain_empty", 32'(empty), 1);

        for (int i = 1; i <= 4; i++) step(1, 8'(i), 0);
        step(1, 8'h09, 1);
        chk("fpp_out", 32'(out), 1);
        chk("fpp_count", 32'(count), 4);
        repeat (4) step(0, 8'h00, 1);
        chk("fpp_last", 32'(out), 9);

        step(1, 8'h42, 1);
`ifdef TC_DELAY_QUEUE_BYPASS_EN
        chk("byp_out", 32'(out), 32'h42);
        chk("byp_count", 32'(count), 0);
        chk("byp_underflow", 32'(underflow), 0);
`else
        chk("epp_valid", 32'(out_valid), 0);
        chk("epp_count", 32'(count), 1);
        chk("epp_underflow", 32'(underflow), 1);
        step(0, 8'h00, 1);
        chk("epp_out", 32'(out), 32'h42);
`endif

        for (int i = 0; i < 10; i++) begin
            step(1, 8'(i), 0);
            step(0, 8'h00, 1);
        end
        chk("wrap_last", 32'(out), 9);
        step(1, 8'h07, 0); step(1, 8'h08, 0);
        chk("pre_rst_count", 32'(count), 2);
        rst = 1'b1;
        @(posedge clk);
        #1;
        mq.delete(); exp_q.delete();
        chk("mid_rst_count", 32'(count), 0);
        chk("mid_rst_out", 32'(out), 0);
        chk("mid_rst_flags", 32'({overflow, underflow}), 0);
        rst = 1'b0;
        step(1, 8'h07, 0);
        step(0, 8'h00, 1);
        chk("post_rst_out", 32'(out), 7);
        repeat (2) @(posedge clk);
        #1;
        chk("scoreboard_drained", 32'(exp_q.size()), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
